// File: rtl/bicintp_feed.sv
// Tap sequencer for the bicubic datapath: turns one pixel request into four
// clamped line-RAM reads and four aligned tap beats (pixels plus weights).
module bicintp_feed #(
   parameter int IMG_W  = 1280,
   parameter int ADDR_W = 11
) (
   input  logic              sys_clk,
   input  logic              sys_rstn,
   input  logic              req_vld,
   output logic              req_rdy,
   input  logic [ADDR_W-1:0] req_x,
   input  logic [7:0]        req_wx_0,
   input  logic [7:0]        req_wx_1,
   input  logic [7:0]        req_wx_2,
   input  logic [7:0]        req_wx_3,
   input  logic [7:0]        req_wy_0,
   input  logic [7:0]        req_wy_1,
   input  logic [7:0]        req_wy_2,
   input  logic [7:0]        req_wy_3,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [15:0]       ram_rd_d0,
   input  logic [15:0]       ram_rd_d1,
   input  logic [15:0]       ram_rd_d2,
   input  logic [15:0]       ram_rd_d3,
   output logic [15:0]       p0,
   output logic [15:0]       p1,
   output logic [15:0]       p2,
   output logic [15:0]       p3,
   output logic [7:0]        w_x,
   output logic [7:0]        w_y_0,
   output logic [7:0]        w_y_1,
   output logic [7:0]        w_y_2,
   output logic [7:0]        w_y_3,
   output logic              intp_enb,
   output logic              busy
);

   localparam int CW = ADDR_W + 2;
   localparam logic [ADDR_W-1:0]    LAST   = ADDR_W'(IMG_W - 1);
   localparam logic signed [CW-1:0] LAST_S = CW'(IMG_W - 1);
   localparam logic signed [CW-1:0] ZERO_S = '0;
   localparam logic signed [CW-1:0] ONE_S  = CW'(1);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        tap_cnt, tap_cnt_nxt;
   logic              rdy_raw;
   logic              load;
   logic [ADDR_W-1:0] x_in;
   logic [ADDR_W-1:0] x_lat;
   logic [3:0][7:0]   wx_lat;
   logic [3:0][7:0]   wy_lat;
   logic signed [CW-1:0] col_s;
   logic [ADDR_W-1:0] col_clamped;
   logic              v1;
   logic [7:0]        wx1;
   logic [3:0][7:0]   wy1;

   // Out-of-range request columns collapse onto the last real column.
   assign x_in = (req_x >= LAST) ? LAST : req_x;

   always_comb begin
      col_s = $signed({2'b00, x_lat}) + $signed({{(CW-2){1'b0}}, tap_cnt}) - ONE_S;
      if (col_s < ZERO_S) begin
         col_clamped = '0;
      end else if (col_s > LAST_S) begin
         col_clamped = LAST;
      end else begin
         col_clamped = col_s[ADDR_W-1:0];
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state   <= IDLE;
         tap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         tap_cnt <= tap_cnt_nxt;
      end
   end

   // A new request may be taken while idle or on the last tap, giving 4-clock pitch.
   always_comb begin
      state_nxt   = state;
      tap_cnt_nxt = tap_cnt;
      rdy_raw     = 1'b0;
      load        = 1'b0;
      ram_rd_en   = 1'b0;
      case (state)
         IDLE: begin
            rdy_raw = 1'b1;
            if (req_vld) begin
               load        = 1'b1;
               state_nxt   = ISSUE;
               tap_cnt_nxt = 2'd0;
            end
         end
         ISSUE: begin
            ram_rd_en   = 1'b1;
            tap_cnt_nxt = tap_cnt + 2'd1;
            if (tap_cnt == 2'd3) begin
               rdy_raw = 1'b1;
               if (req_vld) begin
                  load = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt   = IDLE;
            tap_cnt_nxt = 2'd0;
         end
      endcase
   end

   assign req_rdy     = rdy_raw & sys_rstn;
   assign ram_rd_addr = ram_rd_en ? col_clamped : '0;
   assign busy        = (state == ISSUE) || v1 || intp_enb;

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         x_lat  <= '0;
         wx_lat <= '0;
         wy_lat <= '0;
      end else if (load) begin
         x_lat  <= x_in;
         wx_lat <= {req_wx_3, req_wx_2, req_wx_1, req_wx_0};
         wy_lat <= {req_wy_3, req_wy_2, req_wy_1, req_wy_0};
      end
   end

   // Weights ride alongside their read so a following group cannot overwrite them early.
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         v1       <= 1'b0;
         wx1      <= '0;
         wy1      <= '0;
         intp_enb <= 1'b0;
         p0       <= '0;
         p1       <= '0;
         p2       <= '0;
         p3       <= '0;
         w_x      <= '0;
         w_y_0    <= '0;
         w_y_1    <= '0;
         w_y_2    <= '0;
         w_y_3    <= '0;
      end else begin
         v1       <= ram_rd_en;
         intp_enb <= v1;
         if (ram_rd_en) begin
            wx1 <= wx_lat[tap_cnt];
            wy1 <= wy_lat;
         end
         if (v1) begin
            p0    <= ram_rd_d0;
            p1    <= ram_rd_d1;
            p2    <= ram_rd_d2;
            p3    <= ram_rd_d3;
            w_x   <= wx1;
            w_y_0 <= wy1[0];
            w_y_1 <= wy1[1];
            w_y_2 <= wy1[2];
            w_y_3 <= wy1[3];
         end
      end
   end

endmodule

// File: tb/tb_bicintp_feed.sv
// Self-checking bench for bicintp_feed: line RAM model plus a cycle-stamped
// scoreboard of expected reads and tap beats derived from request timing.
module tb_bicintp_feed;

   localparam int IMG_W  = 1280;
   localparam int ADDR_W = 11;

   logic              sys_clk;
   logic              sys_rstn;
   logic              req_vld;
   logic              req_rdy;
   logic [ADDR_W-1:0] req_x;
   logic [7:0]        req_wx_0, req_wx_1, req_wx_2, req_wx_3;
   logic [7:0]        req_wy_0, req_wy_1, req_wy_2, req_wy_3;
   logic              ram_rd_en;
   logic [ADDR_W-1:0] ram_rd_addr;
   logic [15:0]       ram_rd_d0, ram_rd_d1, ram_rd_d2, ram_rd_d3;
   logic [15:0]       p0, p1, p2, p3;
   logic [7:0]        w_x, w_y_0, w_y_1, w_y_2, w_y_3;
   logic              intp_enb;
   logic              busy;

   bicintp_feed #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
      .sys_clk(sys_clk), .sys_rstn(sys_rstn),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_x(req_x),
      .req_wx_0(req_wx_0), .req_wx_1(req_wx_1), .req_wx_2(req_wx_2), .req_wx_3(req_wx_3),
      .req_wy_0(req_wy_0), .req_wy_1(req_wy_1), .req_wy_2(req_wy_2), .req_wy_3(req_wy_3),
      .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
      .ram_rd_d0(ram_rd_d0), .ram_rd_d1(ram_rd_d1), .ram_rd_d2(ram_rd_d2), .ram_rd_d3(ram_rd_d3),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3),
      .w_x(w_x), .w_y_0(w_y_0), .w_y_1(w_y_1), .w_y_2(w_y_2), .w_y_3(w_y_3),
      .intp_enb(intp_enb), .busy(busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic [15:0] mem [4][IMG_W];

   // Four row RAMs with one clock of read latency.
   always @(posedge sys_clk) begin
      if (ram_rd_en) begin
         ram_rd_d0 <= mem[0][ram_rd_addr];
         ram_rd_d1 <= mem[1][ram_rd_addr];
         ram_rd_d2 <= mem[2][ram_rd_addr];
         ram_rd_d3 <= mem[3][ram_rd_addr];
      end
   end

   typedef struct packed {
      int                cyc;
      logic [ADDR_W-1:0] addr;
   } iss_t;

   typedef struct packed {
      int          cyc;
      logic [63:0] p;
      logic [7:0]  wx;
      logic [31:0] wy;
   } beat_t;

   iss_t  iss_q[$];
   beat_t beat_q[$];
   int    acc_q[$];
   int    cyc;
   bit    have_acc;
   int    last_acc;
   int    checks;
   int    errors;

   function automatic int clampCol(input int x, input int k);
      int xe;
      int c;
      xe = (x >= IMG_W) ? IMG_W - 1 : x;
      c  = xe - 1 + k;
      if (c < 0) c = 0;
      if (c > IMG_W - 1) c = IMG_W - 1;
      return c;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clearModel();
      iss_q.delete();
      beat_q.delete();
      acc_q.delete();
      have_acc = 1'b0;
   endtask

   // One clock: drive inputs, then at the falling edge compare against the scoreboard.
   task automatic applyStimulus(input bit vld, input int x, input logic [31:0] wx, input logic [31:0] wy);
      bit    ready;
      bit    bsy;
      beat_t b;
      int    a;
      @(posedge sys_clk);
      #1;
      cyc++;
      req_vld  = vld;
      req_x    = ADDR_W'(x);
      req_wx_0 = wx[7:0];   req_wx_1 = wx[15:8];  req_wx_2 = wx[23:16]; req_wx_3 = wx[31:24];
      req_wy_0 = wy[7:0];   req_wy_1 = wy[15:8];  req_wy_2 = wy[23:16]; req_wy_3 = wy[31:24];
      @(negedge sys_clk);
      ready = !have_acc || (cyc >= last_acc + 4);
      while (acc_q.size() > 0 && acc_q[0] + 6 < cyc) void'(acc_q.pop_front());
      bsy = 1'b0;
      foreach (acc_q[i]) if (cyc >= acc_q[i] + 1 && cyc <= acc_q[i] + 6) bsy = 1'b1;
      checkOutput("req_rdy", 64'(req_rdy), 64'(ready));
      checkOutput("busy", 64'(busy), 64'(bsy));
      if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
         checkOutput("rd_en", 64'(ram_rd_en), 64'd1);
         checkOutput("rd_addr", 64'(ram_rd_addr), 64'(iss_q[0].addr));
         void'(iss_q.pop_front());
      end else begin
         checkOutput("rd_en", 64'(ram_rd_en), 64'd0);
      end
      if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
         b = beat_q.pop_front();
         checkOutput("intp_enb", 64'(intp_enb), 64'd1);
         checkOutput("pix", {p3, p2, p1, p0}, b.p);
         checkOutput("w_x", 64'(w_x), 64'(b.wx));
         checkOutput("w_y", 64'({w_y_3, w_y_2, w_y_1, w_y_0}), 64'(b.wy));
      end else begin
         checkOutput("intp_enb", 64'(intp_enb), 64'd0);
      end
      if (vld && ready) begin
         have_acc = 1'b1;
         last_acc = cyc;
         acc_q.push_back(cyc);
         for (int k = 0; k < 4; k++) begin
            a = clampCol(x, k);
            iss_q.push_back('{cyc: cyc + 1 + k, addr: ADDR_W'(a)});
            b.cyc = cyc + 3 + k;
            b.p   = {mem[3][a], mem[2][a], mem[1][a], mem[0][a]};
            b.wx  = wx[8*k +: 8];
            b.wy  = wy;
            beat_q.push_back(b);
         end
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 32'd0, 32'd0);
   endtask

   task automatic resetDut(input int n);
      @(posedge sys_clk);
      #1;
      sys_rstn = 1'b0;
      req_vld  = 1'b0;
      clearModel();
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         checkOutput("rst_intp_enb", 64'(intp_enb), 64'd0);
         checkOutput("rst_rd_en", 64'(ram_rd_en), 64'd0);
         checkOutput("rst_busy", 64'(busy), 64'd0);
         checkOutput("rst_req_rdy", 64'(req_rdy), 64'd0);
         @(posedge sys_clk);
         #1;
      end
      sys_rstn = 1'b1;
      @(negedge sys_clk);
      checkOutput("rdy_after_rst", 64'(req_rdy), 64'd1);
   endtask

   initial begin
      int          x;
      logic [31:0] wx;
      logic [31:0] wy;
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      last_acc = 0;
      sys_rstn = 1'b0;
      req_vld  = 1'b0;
      req_x    = '0;
      {req_wx_0, req_wx_1, req_wx_2, req_wx_3} = '0;
      {req_wy_0, req_wy_1, req_wy_2, req_wy_3} = '0;
      for (int r = 0; r < 4; r++)
         for (int a = 0; a < IMG_W; a++) mem[r][a] = 16'($urandom);
      clearModel();
      resetDut(3);

      // Single request, then edge columns and an out-of-range column.
      applyStimulus(1'b1, 100, {8'd4, 8'd3, 8'd2, 8'd1}, 32'h11223344);
      idleCycles(8);
      applyStimulus(1'b1, 0, 32'h0A0B0C0D, 32'h55667788);
      idleCycles(8);
      applyStimulus(1'b1, 1279, 32'h01020304, 32'h99AABBCC);
      idleCycles(8);
      applyStimulus(1'b1, 2000, 32'hF0E0D0C0, 32'h12345678);
      idleCycles(8);

      // Back-to-back: hold req_vld through three requests.
      for (int i = 0; i < 3; i++) begin
         while (1) begin
            applyStimulus(1'b1, 10 * (i + 1), 32'h04030201 + 32'(i), 32'hA0B0C0D0 + 32'(i * 16));
            if (last_acc == cyc) break;
         end
      end
      idleCycles(8);

      // Random traffic with stalls and edge-biased columns.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0: x = 0;
            1: x = 1;
            2: x = IMG_W - 1;
            3: x = $urandom_range(IMG_W - 2, 2047);
            default: x = $urandom_range(0, IMG_W - 1);
         endcase
         wx = $urandom;
         wy = $urandom;
         applyStimulus($urandom_range(0, 2) != 0, x, wx, wy);
      end
      idleCycles(8);

      // Reset in the middle of a group, then a clean group afterwards.
      applyStimulus(1'b1, 500, 32'h44332211, 32'hDEADBEEF);
      idleCycles(2);
      resetDut(2);
      applyStimulus(1'b1, 640, 32'h08070605, 32'hCAFEF00D);
      idleCycles(8);
      checkOutput("beats_drained", 64'(beat_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
